hspi_slave_rx: RTL and testbench

- Receive-side HSPI endpoint on the htclk domain; accepts half-duplex frames from an HSPI master over htreq/htrdy/htvld/hd.
- Frame: 4-byte header, N payload bytes, 2-byte USB-style CRC16.
- Strips the header, streams payload bytes to the application, and reports header fields, byte count and CRC/length status per frame.
- Sits between the HSPI pins and the capture/host-side logic.

---
 rtl/hspi_slave_rx_if.sv | 18 +
 rtl/hspi_slave_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_hspi_slave_rx.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hspi_slave_rx_if.sv
// ---------------------------------------------------------------------------
// hspi_slave_rx_if
// Purpose : HSPI pin bundle between an HSPI master and the receive endpoint.
// Signals : htreq  master transfer request
//           htrdy  slave ready
//           htvld  hd valid, held high for the whole frame
//           hd     frame byte
// Modports: master (drives htreq/htvld/hd), slave (drives htrdy)
// ---------------------------------------------------------------------------
interface hspi_slave_rx_if;
    logic       htreq;
    logic       htrdy;
    logic       htvld;
    logic [7:0] hd;

    modport master (output htreq, output htvld, output hd, input htrdy);
    modport slave  (input htreq, input htvld, input hd, output htrdy);
endinterface

// File: rtl/hspi_slave_rx.sv
// ---------------------------------------------------------------------------
// hspi_slave_rx
// Purpose : Receive-side HSPI endpoint. Accepts a frame of 4 header bytes,
//           N payload bytes and a 2-byte USB-style CRC16, streams the payload
//           and reports header fields, byte count and CRC/length status.
// Ports   : htclk       sole clock (posedge)
//           rst_n       asynchronous active-low reset
//           rx_en       application allows new frames
//           hs          HSPI pins (slave modport: htreq, htrdy, htvld, hd)
//           rx_valid    payload byte strobe, rx_data payload byte
//           rx_sof      first payload byte of a frame
//           frame_done  one-cycle end-of-frame pulse
//           rx_len      payload byte count, rx_usdf/rx_seq header fields
//           crc_ok      CRC matched, len_err length fault, seq_err seq fault
// Option  : HSPI_SLAVE_SEQ_CHECK_EN enables the sequence-number check;
//           without it seq_err is tied low.
// ---------------------------------------------------------------------------
module hspi_slave_rx #(
    parameter int MAX_LEN = 4095,
    parameter int TIMEOUT = 1024
) (
    input  logic           htclk,
    input  logic           rst_n,
    input  logic           rx_en,
    hspi_slave_rx_if.slave hs,
    output logic           rx_valid,
    output logic [7:0]     rx_data,
    output logic           rx_sof,
    output logic           frame_done,
    output logic [11:0]    rx_len,
    output logic [25:0]    rx_usdf,
    output logic [3:0]     rx_seq,
    output logic           crc_ok,
    output logic           len_err,
    output logic           seq_err
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    // Stream index whose arrival proves the payload is longer than MAX_LEN
    localparam logic [12:0] OVF_IDX = 13'(MAX_LEN + 6);

    typedef enum logic [1:0] {IDLE, ARMED, RECV, DONE} state_t;

    // Non-reflected register form: bits enter LSB-first, MSB feeds back x^16+x^15+x^2+1
    function automatic logic [15:0] crcByte(input logic [15:0] r, input logic [7:0] b);
        logic [15:0] c;
        c = r;
        for (int i = 0; i < 8; i++) begin
            c = (c[15] ^ b[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [7:0] bitRev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    state_t        state_q, state_d;
    logic          htrdy_q, htrdy_d;
    logic [TW-1:0] timer_q;
    logic [12:0]   cnt_q;
    logic          ovf_q;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    dl0_q, dl1_q;
    logic [25:0]   usdfAcc_q;
    logic [3:0]    seqAcc_q;
    logic [1:0]    lsbAcc_q;
    logic          popValid_q, popSof_q;
    logic [7:0]    popData_q;
    logic          rxValid_q, rxSof_q, frameDone_q, crcOk_q, lenErr_q;
    logic [7:0]    rxData_q;
    logic [11:0]   rxLen_q;
    logic [25:0]   rxUsdf_q;
    logic [3:0]    rxSeq_q;

    logic          take, endNow, isHdr, ovfNow, popNow, crcOk_d, lenErr_d;
    logic [11:0]   len_d;

    // Handshake FSM: arm on request, receive while htvld, one DONE cycle
    always_comb begin
        state_d = state_q;
        htrdy_d = htrdy_q;
        case (state_q)
            IDLE: begin
                if (hs.htreq && rx_en && !hs.htvld) begin
                    state_d = ARMED;
                    htrdy_d = 1'b1;
                end
            end
            ARMED: begin
                if (hs.htvld) begin
                    state_d = RECV;
                end else if (!hs.htreq || (timer_q == TW'(TIMEOUT - 1))) begin
                    state_d = IDLE;
                    htrdy_d = 1'b0;
                end
            end
            RECV: begin
                if (!hs.htvld) begin
                    state_d = DONE;
                    htrdy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge htclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            htrdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            htrdy_q <= htrdy_d;
        end
    end

    // Datapath decisions. Header bytes go straight into the CRC; payload and
    // CRC bytes pass through a 2-deep delay line so the trailing CRC pair is
    // still held there when htvld falls and is never emitted.
    always_comb begin
        take     = hs.htvld && ((state_q == ARMED) || (state_q == RECV));
        endNow   = (state_q == RECV) && !hs.htvld;
        isHdr    = take && (cnt_q < 13'd4);
        ovfNow   = take && !ovf_q && (cnt_q == OVF_IDX);
        popNow   = take && !ovf_q && (cnt_q >= 13'd6) && !ovfNow;
        crc_d    = crc_q;
        if (isHdr) begin
            crc_d = crcByte(crc_q, hs.hd);
        end else if (popNow) begin
            crc_d = crcByte(crc_q, dl1_q);
        end
        len_d    = 12'(cnt_q - 13'd6);
        lenErr_d = (cnt_q < 13'd6) || ovf_q || (len_d[1:0] != lsbAcc_q);
        crcOk_d  = !ovf_q && (cnt_q >= 13'd6)
                   && (dl1_q == bitRev8(~crc_q[15:8]))
                   && (dl0_q == bitRev8(~crc_q[7:0]));
    end

    always_ff @(posedge htclk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            crc_q       <= 16'hFFFF;
            dl0_q       <= '0;
            dl1_q       <= '0;
            usdfAcc_q   <= '0;
            seqAcc_q    <= '0;
            lsbAcc_q    <= '0;
            popValid_q  <= 1'b0;
            popSof_q    <= 1'b0;
            popData_q   <= '0;
            rxValid_q   <= 1'b0;
            rxSof_q     <= 1'b0;
            rxData_q    <= '0;
            frameDone_q <= 1'b0;
            rxLen_q     <= '0;
            rxUsdf_q    <= '0;
            rxSeq_q     <= '0;
            crcOk_q     <= 1'b0;
            lenErr_q    <= 1'b0;
        end else begin
            timer_q <= (state_q == ARMED) ? timer_q + TW'(1) : '0;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
                crc_q <= 16'hFFFF;
            end else begin
                crc_q <= crc_d;
                if (take && !ovf_q && !ovfNow) cnt_q <= cnt_q + 13'd1;
                if (ovfNow) ovf_q <= 1'b1;
            end
            if (isHdr) begin
                case (cnt_q[1:0])
                    2'd0: usdfAcc_q[7:0]   <= hs.hd;
                    2'd1: usdfAcc_q[15:8]  <= hs.hd;
                    2'd2: usdfAcc_q[23:16] <= hs.hd;
                    default: begin
                        usdfAcc_q[25:24] <= hs.hd[1:0];
                        seqAcc_q         <= hs.hd[5:2];
                        lsbAcc_q         <= hs.hd[7:6];
                    end
                endcase
            end
            if (take && !ovf_q && !ovfNow && (cnt_q >= 13'd4)) begin
                dl1_q <= dl0_q;
                dl0_q <= hs.hd;
            end
            // Extra output stage gives the 3-cycle hd-to-rx_data latency
            popValid_q <= popNow;
            popSof_q   <= popNow && (cnt_q == 13'd6);
            if (popNow) popData_q <= dl1_q;
            rxValid_q  <= popValid_q;
            rxSof_q    <= popSof_q;
            if (popValid_q) rxData_q <= popData_q;
            frameDone_q <= endNow;
            if (endNow) begin
                rxLen_q  <= len_d;
                rxUsdf_q <= usdfAcc_q;
                rxSeq_q  <= seqAcc_q;
                crcOk_q  <= crcOk_d;
                lenErr_q <= lenErr_d;
            end
        end
    end

`ifdef HSPI_SLAVE_SEQ_CHECK_EN
    logic [3:0] expSeq_q;
    logic       seqErr_q;

    // Only frames with a good CRC are trusted to advance the expected number
    always_ff @(posedge htclk or negedge rst_n) begin
        if (!rst_n) begin
            expSeq_q <= '0;
            seqErr_q <= 1'b0;
        end else if (endNow) begin
            if (crcOk_d) begin
                seqErr_q <= (seqAcc_q != expSeq_q);
                expSeq_q <= seqAcc_q + 4'd1;
            end else begin
                seqErr_q <= 1'b0;
            end
        end
    end

    assign seq_err = seqErr_q;
`else
    assign seq_err = 1'b0;
`endif

    assign hs.htrdy   = htrdy_q;
    assign rx_valid   = rxValid_q;
    assign rx_data    = rxData_q;
    assign rx_sof     = rxSof_q;
    assign frame_done = frameDone_q;
    assign rx_len     = rxLen_q;
    assign rx_usdf    = rxUsdf_q;
    assign rx_seq     = rxSeq_q;
    assign crc_ok     = crcOk_q;
    assign len_err    = lenErr_q;

endmodule

// File: tb/tb_hspi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_hspi_slave_rx
// Self-checking bench for hspi_slave_rx: a table of frames with expected
// status, a payload scoreboard queue, and hand-written corner sequences
// (runt, timeout, request drop, reset mid-frame).
// ---------------------------------------------------------------------------
module tb_hspi_slave_rx;

    localparam int MAX_LEN = 8;
    localparam int TIMEOUT = 40;

    logic        htclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_valid, rx_sof, frame_done, crc_ok, len_err, seq_err;
    logic [7:0]  rx_data;
    logic [11:0] rx_len;
    logic [25:0] rx_usdf;
    logic [3:0]  rx_seq;

    hspi_slave_rx_if hsIf();

    hspi_slave_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .htclk      (htclk),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .hs         (hsIf),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_sof     (rx_sof),
        .frame_done (frame_done),
        .rx_len     (rx_len),
        .rx_usdf    (rx_usdf),
        .rx_seq     (rx_seq),
        .crc_ok     (crc_ok),
        .len_err    (len_err),
        .seq_err    (seq_err)
    );

    always #5 htclk = ~htclk;

    typedef struct {
        logic        resetBefore;
        logic [25:0] usdf;
        logic [3:0]  seq;
        logic [1:0]  lenLsb;
        int          payLen;
        logic [7:0]  payBase;
        logic        corrupt;
        logic        expCrcOk;
        logic        expLenErr;
        logic [11:0] expLen;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       sof;
    } sb_t;

    vec_t       vecs[10];
    sb_t        sbQ[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    int         frameDoneCnt = 0;
    logic [3:0] expSeqModel = 4'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reflected CRC-16/USB reference step (poly 0xA001, LSB-first)
    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // Scoreboard: every payload strobe must match the next queued byte
    always @(negedge htclk) begin : monitor
        sb_t e;
        if (rst_n && rx_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected rx_valid", 32'(rx_valid), 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                checkOutput("rx_sof", 32'(rx_sof), 32'(e.sof));
            end
        end
        if (frame_done) frameDoneCnt++;
    end

    task automatic doReset();
        rst_n = 1'b0;
        hsIf.htreq = 1'b0;
        hsIf.htvld = 1'b0;
        hsIf.hd = 8'h00;
        repeat (2) @(posedge htclk);
        #1 rst_n = 1'b1;
        expSeqModel = 4'd0;
    endtask

    task automatic armHandshake(input string name);
        @(posedge htclk);
        #1 hsIf.htreq = 1'b1;
        @(posedge htclk);
        @(negedge htclk);
        checkOutput(name, 32'(hsIf.htrdy), 1);
    endtask

    task automatic driveByte(input logic [7:0] b);
        @(posedge htclk);
        #1 hsIf.htvld = 1'b1;
        hsIf.hd = b;
    endtask

    task automatic endFrame();
        @(posedge htclk);
        #1 hsIf.htvld = 1'b0;
        hsIf.htreq = 1'b0;
        hsIf.hd = 8'h00;
    endtask

    task automatic waitFrameDone(output logic got);
        int t;
        got = 1'b0;
        t = 0;
        while (!got && t < 20) begin
            @(negedge htclk);
            if (frame_done) got = 1'b1;
            t++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0]  bytes[$];
        logic [15:0] c;
        logic        got, expSeqErr;
        int          nEmit, doneBefore;
        sb_t         e;
        if (v.resetBefore) doReset();
        bytes = {};
        bytes.push_back(v.usdf[7:0]);
        bytes.push_back(v.usdf[15:8]);
        bytes.push_back(v.usdf[23:16]);
        bytes.push_back({v.lenLsb, v.seq, v.usdf[25:24]});
        for (int k = 0; k < v.payLen; k++) bytes.push_back(v.payBase + 8'(k * 17));
        c = 16'hFFFF;
        foreach (bytes[i]) c = crcStep(c, bytes[i]);
        c = ~c;
        bytes.push_back(c[7:0]);
        bytes.push_back(c[15:8]);
        if (v.corrupt) bytes[bytes.size() - 1] ^= 8'h01;
        nEmit = (v.payLen > MAX_LEN) ? MAX_LEN : v.payLen;
        for (int k = 0; k < nEmit; k++) begin
            e.data = bytes[4 + k];
            e.sof = (k == 0);
            sbQ.push_back(e);
        end
        expSeqErr = 1'b0;
`ifdef HSPI_SLAVE_SEQ_CHECK_EN
        if (v.expCrcOk) begin
            expSeqErr = (v.seq != expSeqModel);
            expSeqModel = v.seq + 4'd1;
        end
`endif
        doneBefore = frameDoneCnt;
        armHandshake("htrdy next cycle");
        foreach (bytes[i]) driveByte(bytes[i]);
        endFrame();
        waitFrameDone(got);
        checkOutput("frame_done seen", 32'(got), 1);
        if (got) begin
            if (v.payLen <= MAX_LEN) checkOutput("rx_len", 32'(rx_len), 32'(v.expLen));
            checkOutput("rx_usdf", 32'(rx_usdf), 32'(v.usdf));
            checkOutput("rx_seq", 32'(rx_seq), 32'(v.seq));
            checkOutput("crc_ok", 32'(crc_ok), 32'(v.expCrcOk));
            checkOutput("len_err", 32'(len_err), 32'(v.expLenErr));
            checkOutput("seq_err", 32'(seq_err), 32'(expSeqErr));
        end
        repeat (4) @(negedge htclk);
        checkOutput("payload drained", 32'(sbQ.size()), 0);
        checkOutput("one frame_done", 32'(frameDoneCnt - doneBefore), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic got;
        int   highCnt, doneBefore;
        logic [7:0] b;

        vecs[0] = '{1'b0, 26'h2ABCDEF, 4'd5, 2'd0, 4,  8'h11, 1'b0, 1'b1, 1'b0, 12'd4};
        vecs[1] = '{1'b0, 26'h2ABCDEF, 4'd5, 2'd0, 4,  8'h11, 1'b1, 1'b0, 1'b0, 12'd4};
        vecs[2] = '{1'b0, 26'h0000001, 4'd6, 2'd0, 0,  8'hA0, 1'b0, 1'b1, 1'b0, 12'd0};
        vecs[3] = '{1'b0, 26'h3FFFFFF, 4'd7, 2'd0, 8,  8'h01, 1'b0, 1'b1, 1'b0, 12'd8};
        vecs[4] = '{1'b0, 26'h1234567, 4'd8, 2'd0, 5,  8'h30, 1'b0, 1'b1, 1'b1, 12'd5};
        vecs[5] = '{1'b0, 26'h0F0F0F0, 4'd9, 2'd3, 3,  8'hC0, 1'b0, 1'b1, 1'b0, 12'd3};
        vecs[6] = '{1'b0, 26'h2000000, 4'd10, 2'd2, 10, 8'h05, 1'b0, 1'b0, 1'b1, 12'd0};
        vecs[7] = '{1'b1, 26'h0000AAA, 4'd0, 2'd1, 1,  8'h77, 1'b0, 1'b1, 1'b0, 12'd1};
        vecs[8] = '{1'b0, 26'h0000BBB, 4'd1, 2'd2, 2,  8'h88, 1'b0, 1'b1, 1'b0, 12'd2};
        vecs[9] = '{1'b0, 26'h0000CCC, 4'd3, 2'd0, 4,  8'h99, 1'b0, 1'b1, 1'b0, 12'd4};

        hsIf.htreq = 1'b0;
        hsIf.htvld = 1'b0;
        hsIf.hd = 8'h00;
        #1;
        checkOutput("reset htrdy", 32'(hsIf.htrdy), 0);
        checkOutput("reset rx_valid", 32'(rx_valid), 0);
        checkOutput("reset rx_sof", 32'(rx_sof), 0);
        checkOutput("reset frame_done", 32'(frame_done), 0);
        checkOutput("reset rx_data", 32'(rx_data), 0);
        checkOutput("reset rx_len", 32'(rx_len), 0);
        checkOutput("reset rx_usdf", 32'(rx_usdf), 0);
        checkOutput("reset rx_seq", 32'(rx_seq), 0);
        checkOutput("reset crc_ok", 32'(crc_ok), 0);
        checkOutput("reset len_err", 32'(len_err), 0);
        checkOutput("reset seq_err", 32'(seq_err), 0);
        rx_en = 1'b1;
        doReset();

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Runt frame: three bytes only
        $display("[TB] runt frame");
        armHandshake("runt htrdy");
        driveByte(8'h12);
        driveByte(8'h34);
        driveByte(8'h56);
        endFrame();
        waitFrameDone(got);
        checkOutput("runt frame_done seen", 32'(got), 1);
        checkOutput("runt len_err", 32'(len_err), 1);
        checkOutput("runt crc_ok", 32'(crc_ok), 0);
        checkOutput("runt seq_err", 32'(seq_err), 0);
        repeat (3) @(negedge htclk);

        // Timeout: htrdy must stay up for exactly TIMEOUT cycles
        $display("[TB] timeout");
        doneBefore = frameDoneCnt;
        armHandshake("timeout htrdy");
        highCnt = 1;
        got = 1'b0;
        for (int t = 0; t < TIMEOUT + 10; t++) begin
            if (!got) begin
                @(negedge htclk);
                if (hsIf.htrdy) highCnt++;
                else got = 1'b1;
            end
        end
        hsIf.htreq = 1'b0;
        checkOutput("timeout htrdy fell", 32'(got), 1);
        checkOutput("timeout htrdy cycles", 32'(highCnt), 32'(TIMEOUT));
        repeat (3) @(negedge htclk);
        checkOutput("timeout htrdy stays low", 32'(hsIf.htrdy), 0);
        checkOutput("timeout no frame_done", 32'(frameDoneCnt - doneBefore), 0);

        // Request withdrawn while armed
        armHandshake("drop htrdy");
        @(posedge htclk);
        #1 hsIf.htreq = 1'b0;
        @(posedge htclk);
        @(negedge htclk);
        checkOutput("htreq drop clears htrdy", 32'(hsIf.htrdy), 0);

        // Reset during payload byte 2, released while htvld still high
        $display("[TB] reset mid-frame");
        doneBefore = frameDoneCnt;
        armHandshake("midreset htrdy");
        for (int k = 0; k < 12; k++) begin
            b = 8'h50 + 8'(k);
            if (k == 6) begin
                @(posedge htclk);
                #1 rst_n = 1'b0;
                hsIf.htvld = 1'b1;
                hsIf.hd = b;
                #1;
                checkOutput("midreset htrdy", 32'(hsIf.htrdy), 0);
                checkOutput("midreset crc_ok", 32'(crc_ok), 0);
                checkOutput("midreset rx_seq", 32'(rx_seq), 0);
            end else if (k == 7) begin
                @(posedge htclk);
                #1 rst_n = 1'b1;
                hsIf.hd = b;
                expSeqModel = 4'd0;
            end else begin
                driveByte(b);
            end
        end
        endFrame();
        repeat (8) @(negedge htclk);
        checkOutput("midreset no frame_done", 32'(frameDoneCnt - doneBefore), 0);
        checkOutput("midreset htrdy idle", 32'(hsIf.htrdy), 0);
        applyStimulus(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
